// File: rtl/fp_mul_seq.sv
//==============================================================================
// Module  : fp_mul_seq
// Brief   : Sequential IEEE-754 single-precision multiplier, radix-2 shift-add
//           significand product, truncating, with start/done handshake.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_mul_seq #(
  parameter int BIAS = 127,
  parameter int MW   = 24
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  exception
);

  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW);

  localparam logic [1:0] c_exc_none  = 2'b00;
  localparam logic [1:0] c_exc_under = 2'b01;
  localparam logic [1:0] c_exc_over  = 2'b10;
  localparam logic [1:0] c_exc_nan   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [MW-1:0]   mcand_q,     mcand_d;
  logic [MW-1:0]   mplier_q,    mplier_d;
  logic [PW-1:0]   acc_q,       acc_d;
  logic [CW-1:0]   count_q,     count_d;
  logic [9:0]      esum_q,      esum_d;
  logic            sign_q,      sign_d;
  logic            busy_q,      busy_d;
  logic            done_q,      done_d;
  logic [31:0]     result_q,    result_d;
  logic [1:0]      exception_q, exception_d;

  // Operand classification (denormals are treated as zero)
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
  assign a_zero  = (a[30:23] == 8'h00);
  assign b_zero  = (b[30:23] == 8'h00);
  assign a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign sign_in = a[31] ^ b[31];

  logic [PW-1:0]   partial;
  logic [9:0]      e_norm;
  logic [MW-2:0]   frac_norm;
  assign partial   = {{MW{1'b0}}, mcand_q} << count_q;
  assign e_norm    = esum_q + {9'd0, acc_q[PW-1]};
  assign frac_norm = acc_q[PW-1] ? acc_q[PW-2 -: MW-1] : acc_q[PW-3 -: MW-1];

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    esum_d      = esum_q;
    sign_d      = sign_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    exception_d = exception_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = sign_in;
          if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            result_d    = 32'h7FFF_FFFF;
            exception_d = c_exc_nan;
            done_d      = 1'b1;
          end else if (a_inf || b_inf) begin
            result_d    = {sign_in, 8'hFF, 23'd0};
            exception_d = c_exc_none;
            done_d      = 1'b1;
          end else if (a_zero || b_zero) begin
            result_d    = {sign_in, 31'd0};
            exception_d = c_exc_none;
            done_d      = 1'b1;
          end else begin
            mcand_d  = {1'b1, a[22:0]};
            mplier_d = {1'b1, b[22:0]};
            acc_d    = '0;
            count_d  = '0;
            esum_d   = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'(BIAS);
            busy_d   = 1'b1;
            state_d  = MUL;
          end
        end
      end

      MUL: begin
        if (mplier_q[0]) acc_d = acc_q + partial;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(MW - 1)) state_d = NORM;
      end

      NORM: begin
        // e_norm is a signed biased exponent; compare as signed
        if ($signed(e_norm) >= 10'sd255) begin
          result_d    = {sign_q, 8'hFF, 23'd0};
          exception_d = c_exc_over;
        end else if ($signed(e_norm) <= 10'sd0) begin
          result_d    = {sign_q, 31'd0};
          exception_d = c_exc_under;
        end else begin
          result_d    = {sign_q, e_norm[7:0], frac_norm};
          exception_d = c_exc_none;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      esum_q      <= '0;
      sign_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      exception_q <= c_exc_none;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      esum_q      <= esum_d;
      sign_q      <= sign_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      exception_q <= exception_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign exception = exception_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
//==============================================================================
// Module  : tb_fp_mul_seq
// Brief   : Vector table plus hand sequences for fp_mul_seq, scoreboard-checked.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fp_mul_seq;

  logic        clk;
  logic        RESET;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  exception;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [1:0]  exc;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  exc;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];

  fp_mul_seq #(.BIAS(127), .MW(24)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .exception(exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest pending request
  always @(negedge clk) begin
    if (!RESET && done) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got result %h exc %b, expected no completion", result, exception);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (result !== e.res || exception !== e.exc) begin
          miscompares++;
          $display("FAIL result: got %h/%b, expected %h/%b", result, exception, e.res, e.exc);
        end
      end
    end
  end

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic [47:0] p;
    int          e;
    logic [22:0] f;
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      f = p[46:24];
    end else begin
      f = p[45:23];
    end
    if (e >= 255)    begin r.res = {x[31]^y[31], 8'hFF, 23'd0}; r.exc = 2'b10; end
    else if (e <= 0) begin r.res = {x[31]^y[31], 31'd0};        r.exc = 2'b01; end
    else             begin r.res = {x[31]^y[31], e[7:0], f};    r.exc = 2'b00; end
    return r;
  endfunction

  // Drive one request ahead of the next edge; returns #1 after the accepting edge
  task automatic launch(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] er, input logic [1:0] ee);
    exp_t e;
    e.res = er;
    e.exc = ee;
    a = va;
    b = vb;
    start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done and busy cycles seen on the way
  task automatic wait_done(input string name, input int exp_lat, input bit chk_drop);
    int n = 0;
    int bc = 0;
    while (!done && n < 60) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_busy_cycles"}, bc, exp_lat);
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    if (chk_drop) begin
      @(posedge clk); #1;
      check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    //            a             b             result        exc    latency
    tbl.push_back('{32'h3FC00000, 32'h3FA00000, 32'h3FF00000, 2'b00, 25});
    tbl.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00, 25});
    tbl.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, 2'b00, 25});
    tbl.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 2'b10, 25});
    tbl.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 2'b01, 25});
    tbl.push_back('{32'h00000000, 32'h7F800000, 32'h7FFFFFFF, 2'b11, 0});
    tbl.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 2'b11, 0});
    tbl.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 2'b00, 0});
    tbl.push_back('{32'h7F800000, 32'h7F800000, 32'h7F800000, 2'b00, 0});
    tbl.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 2'b00, 0});
    tbl.push_back('{32'h00000001, 32'h40000000, 32'h00000000, 2'b00, 0});
    tbl.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 2'b00, 25});
    tbl.push_back('{32'h3F800000, 32'h00800000, 32'h00800000, 2'b00, 25});
    tbl.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 2'b00, 25});
    tbl.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 2'b10, 25});
    tbl.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 2'b01, 25});
    tbl.push_back('{32'hBFC00000, 32'hBFC00000, 32'h40100000, 2'b00, 25});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      exp_t m;
      v.a = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      v.b = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
      m = model(v.a, v.b);
      v.res = m.res;
      v.exc = m.exc;
      v.lat = 25;
      tbl.push_back(v);
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",      {31'd0, busy}, 32'd0);
    check("reset_done",      {31'd0, done}, 32'd0);
    check("reset_result",    result, 32'd0);
    check("reset_exception", {30'd0, exception}, 32'd0);
    @(negedge clk);
    RESET = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      launch(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc);
      wait_done($sformatf("vec%0d", i), tbl[i].lat, 1'b1);
    end

    // Restart attempt mid-operation is ignored, then start held in the done cycle
    launch(32'h3FC00000, 32'h3FA00000, 32'h3FF00000, 2'b00);
    repeat (4) begin @(posedge clk); #1; end
    a = 32'h40000000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'hDEADBEEF;
    b = 32'h12345678;
    wait_done("ignored_start", 20, 1'b0);
    launch(32'hC0000000, 32'h40400000, 32'hC0C00000, 2'b00);
    check("done_cycle_accept_busy", {31'd0, busy}, 32'd1);
    wait_done("done_cycle_accept", 25, 1'b1);

    // Asynchronous reset in the middle of the multiply
    launch(32'h3FC00000, 32'h3FC00000, 32'h40100000, 2'b00);
    repeat (9) begin @(posedge clk); #1; end
    sb_q.delete();
    RESET = 1'b1;
    #1;
    check("midreset_busy",      {31'd0, busy}, 32'd0);
    check("midreset_done",      {31'd0, done}, 32'd0);
    check("midreset_result",    result, 32'd0);
    check("midreset_exception", {30'd0, exception}, 32'd0);
    @(negedge clk);
    RESET = 1'b0;
    begin
      int seen = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      check("no_done_after_abort", seen, 0);
    end
    launch(32'h3FC00000, 32'hC0400000, 32'hC0900000, 2'b00);
    wait_done("after_reset", 25, 1'b1);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
